// File: rtl/pcoeff_sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// pcoeff_pkg
// Shared definitions for the partition-coefficient sum collector:
//   SUM_WIDTH_DEF / BOT_COUNT_WIDTH_DEF : default widths of batch sum / counter
//   CC_WIDTH                            : width of connectCount from the core
//   pcoeff_entry_t                      : result FIFO entry at default widths
// Optional feature macro: PCOEFF_OVERFLOW_CHECK_EN adds the ovf entry field.
// -----------------------------------------------------------------------------
package pcoeff_pkg;

  localparam int SUM_WIDTH_DEF       = 48;
  localparam int BOT_COUNT_WIDTH_DEF = 32;
  localparam int CC_WIDTH            = 6;

  typedef struct packed {
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    logic                           ovf;
`endif
    logic                           ecc;
    logic [BOT_COUNT_WIDTH_DEF-1:0] cnt;
    logic [SUM_WIDTH_DEF-1:0]       sum;
  } pcoeff_entry_t;

endpackage

// File: rtl/pcoeff_sum_collector_if.sv
// -----------------------------------------------------------------------------
// pcoeff_sum_collector_if
// Batch-result bus between the collector (master) and its consumer (slave).
//   outValid/outReady : valid/ready handshake, pop on both high
//   outSum            : batch sum of 2^connectCount
//   outBotCount       : number of valid results in the batch
//   outEcc            : upstream ECC event seen during the batch
//   outOverflow       : only with PCOEFF_OVERFLOW_CHECK_EN
// -----------------------------------------------------------------------------
interface pcoeff_sum_collector_if #(
  parameter int SUM_WIDTH       = 48,
  parameter int BOT_COUNT_WIDTH = 32
);
  logic                       outValid;
  logic                       outReady;
  logic [SUM_WIDTH-1:0]       outSum;
  logic [BOT_COUNT_WIDTH-1:0] outBotCount;
  logic                       outEcc;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
  logic                       outOverflow;

  modport master (output outValid, outSum, outBotCount, outEcc, outOverflow, input outReady);
  modport slave  (input outValid, outSum, outBotCount, outEcc, outOverflow, output outReady);
`else
  modport master (output outValid, outSum, outBotCount, outEcc, input outReady);
  modport slave  (input outValid, outSum, outBotCount, outEcc, output outReady);
`endif
endinterface

// File: rtl/pcoeff_sum_collector_fifo.sv
// -----------------------------------------------------------------------------
// pcoeff_result_fifo
// Synchronous show-ahead register FIFO.
//   i_push/i_data   : write request and entry
//   i_pop           : read request (ignored when empty)
//   o_valid/o_data  : head entry presented while not empty
//   o_almost_full   : registered, used entries >= DEPTH-2
//   o_drop          : push refused (full with no simultaneous pop)
// A push and pop in the same cycle both succeed, even when full.
// -----------------------------------------------------------------------------
module pcoeff_result_fifo #(
  parameter int WIDTH      = 81,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_almost_full,
  output logic             o_drop
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(DEPTH - 2);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_used;
  logic                  r_almost_full;

  logic                  w_full;
  logic                  w_do_pop;
  logic                  w_do_push;
  logic [DEPTH_LOG2:0]   w_used_next;

  // Push/pop qualification and next occupancy.
  always_comb begin
    w_full    = (r_used == FULL_CNT);
    w_do_pop  = i_pop && (r_used != '0);
    // A pop frees the slot the push needs, so full+pop still accepts.
    w_do_push = i_push && (!w_full || w_do_pop);
    case ({w_do_push, w_do_pop})
      2'b10:   w_used_next = r_used + (DEPTH_LOG2+1)'(1);
      2'b01:   w_used_next = r_used - (DEPTH_LOG2+1)'(1);
      default: w_used_next = r_used;
    endcase
  end

  // Pointer, occupancy and almost-full state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_used        <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_used        <= w_used_next;
      r_almost_full <= (w_used_next >= AF_CNT);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid       = (r_used != '0);
  assign o_data        = r_mem[r_rd_ptr];
  assign o_almost_full = r_almost_full;
  assign o_drop        = i_push && w_full && !w_do_pop;
endmodule

// File: rtl/pcoeff_sum_collector.sv
// -----------------------------------------------------------------------------
// pcoeff_sum_collector
// Accumulates 2^connectCount per batch and queues batch results.
//   clk, rst_n (sync, active-low)
//   resultValid, connectCount, batchEnd, eccIn : per-cycle input from the core
//   almostFull : registered throttle request to the bot source
//   lostBatch  : sticky, a batch closed while the result FIFO was full
//   res_if     : batch result bus (master side)
// Optional: PCOEFF_OVERFLOW_CHECK_EN adds outOverflow to the result bus.
// -----------------------------------------------------------------------------
module pcoeff_sum_collector
  import pcoeff_pkg::*;
#(
  parameter int SUM_WIDTH       = SUM_WIDTH_DEF,
  parameter int BOT_COUNT_WIDTH = BOT_COUNT_WIDTH_DEF,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                resultValid,
  input  logic [CC_WIDTH-1:0] connectCount,
  input  logic                batchEnd,
  input  logic                eccIn,
  output logic                almostFull,
  output logic                lostBatch,
  pcoeff_sum_collector_if.master res_if
);
  typedef struct packed {
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    logic                       ovf;
`endif
    logic                       ecc;
    logic [BOT_COUNT_WIDTH-1:0] cnt;
    logic [SUM_WIDTH-1:0]       sum;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);

  logic [SUM_WIDTH-1:0]       r_term_s1;
  logic                       r_valid_s1;
  logic                       r_end_s1;
  logic                       r_ecc_s1;
  logic [SUM_WIDTH-1:0]       r_acc;
  logic [BOT_COUNT_WIDTH-1:0] r_cnt;
  logic                       r_ecc_acc;
  logic                       r_lost;

  logic [SUM_WIDTH-1:0]       w_term;
  logic [SUM_WIDTH-1:0]       w_sum;
  logic [BOT_COUNT_WIDTH-1:0] w_cnt_next;
  entry_t                     w_entry;
  entry_t                     w_head;
  logic [ENTRY_W-1:0]         w_rd_data;
  logic                       w_valid;
  logic                       w_drop;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
  logic                       w_big;
  logic                       r_big_s1;
  logic                       r_ovf;
  logic [SUM_WIDTH:0]         w_sum_ext;
`endif

  // Decode one-hot term; counts beyond the sum width contribute nothing.
  always_comb begin
    w_term = '0;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    w_big  = 1'b0;
`endif
    if (resultValid && (32'(connectCount) < 32'(SUM_WIDTH))) begin
      w_term = SUM_WIDTH'(1) << connectCount;
    end else begin
      w_term = '0;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      w_big  = resultValid;
`endif
    end
  end

  // Stage 1: register decoded term and per-cycle flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_term_s1  <= '0;
      r_valid_s1 <= 1'b0;
      r_end_s1   <= 1'b0;
      r_ecc_s1   <= 1'b0;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      r_big_s1   <= 1'b0;
`endif
    end else begin
      r_term_s1  <= w_term;
      r_valid_s1 <= resultValid;
      r_end_s1   <= batchEnd;
      r_ecc_s1   <= eccIn;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      r_big_s1   <= w_big;
`endif
    end
  end

  // Next accumulator values; these are also the entry pushed at batch end.
  always_comb begin
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    w_sum_ext = {1'b0, r_acc} + {1'b0, r_term_s1};
    w_sum     = w_sum_ext[SUM_WIDTH-1:0];
`else
    w_sum     = r_acc + r_term_s1;
`endif
    // Counter saturates at all-ones.
    if (r_valid_s1 && (r_cnt != '1)) begin
      w_cnt_next = r_cnt + BOT_COUNT_WIDTH'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
    w_entry.sum = w_sum;
    w_entry.cnt = w_cnt_next;
    w_entry.ecc = r_ecc_acc | r_ecc_s1;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    w_entry.ovf = r_ovf | r_big_s1 | w_sum_ext[SUM_WIDTH];
`endif
  end

  // Stage 2: accumulate, or restart from zero on the batch-closing edge.
  always_ff @(posedge clk) begin
    if (!rst_n || r_end_s1) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ecc_acc <= 1'b0;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_acc     <= w_sum;
      r_cnt     <= w_cnt_next;
      r_ecc_acc <= w_entry.ecc;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      r_ovf     <= w_entry.ovf;
`endif
    end
  end

  // Sticky lost-batch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lost <= 1'b0;
    end else if (w_drop) begin
      r_lost <= 1'b1;
    end else begin
      r_lost <= r_lost;
    end
  end

  pcoeff_result_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (r_end_s1),
    .i_data        (w_entry),
    .i_pop         (w_valid && res_if.outReady),
    .o_valid       (w_valid),
    .o_data        (w_rd_data),
    .o_almost_full (almostFull),
    .o_drop        (w_drop)
  );

  assign w_head             = entry_t'(w_rd_data);
  assign res_if.outValid    = w_valid;
  assign res_if.outSum      = w_head.sum;
  assign res_if.outBotCount = w_head.cnt;
  assign res_if.outEcc      = w_head.ecc;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
  assign res_if.outOverflow = w_head.ovf;
`endif
  assign lostBatch          = r_lost;
endmodule

// File: tb/tb_pcoeff_sum_collector.sv
module tb_pcoeff_sum_collector;
  import pcoeff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       resultValid;
  logic [5:0] connectCount;
  logic       batchEnd;
  logic       eccIn;
  logic       almostFull;
  logic       lostBatch;

  pcoeff_sum_collector_if #(.SUM_WIDTH(48), .BOT_COUNT_WIDTH(32)) res_if ();

  pcoeff_sum_collector #(
    .SUM_WIDTH       (48),
    .BOT_COUNT_WIDTH (32),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .resultValid  (resultValid),
    .connectCount (connectCount),
    .batchEnd     (batchEnd),
    .eccIn        (eccIn),
    .almostFull   (almostFull),
    .lostBatch    (lostBatch),
    .res_if       (res_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: entries the FIFO should hold, plus the batch in flight.
  pcoeff_entry_t q[$];
  pcoeff_entry_t pend;
  logic          pend_v;
  logic [47:0]   m_acc;
  logic [31:0]   m_cnt;
  logic          m_ecc;
  logic          m_ovf;
  logic          m_lost;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend_v = 1'b0;
    m_acc  = '0;
    m_cnt  = '0;
    m_ecc  = 1'b0;
    m_ovf  = 1'b0;
    m_lost = 1'b0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input logic [5:0] c, input logic e,
                      input logic ecc, input logic rdy);
    logic          popping;
    logic          full_before;
    logic [48:0]   s;
    logic          big;
    pcoeff_entry_t nxt;
    check("outValid",   64'(res_if.outValid), 64'(q.size() > 0));
    check("almostFull", 64'(almostFull),      64'(q.size() >= 2));
    check("lostBatch",  64'(lostBatch),       64'(m_lost));
    if (q.size() > 0) begin
      check("outSum",      64'(res_if.outSum),      64'(q[0].sum));
      check("outBotCount", 64'(res_if.outBotCount), 64'(q[0].cnt));
      check("outEcc",      64'(res_if.outEcc),      64'(q[0].ecc));
`ifdef PCOEFF_OVERFLOW_CHECK_EN
      check("outOverflow", 64'(res_if.outOverflow), 64'(q[0].ovf));
`endif
    end
    resultValid     = v;
    connectCount    = c;
    batchEnd        = e;
    eccIn           = ecc;
    res_if.outReady = rdy;
    popping     = (q.size() > 0) && rdy;
    full_before = (q.size() == 4);
    big = v && (c >= 6'd48);
    s   = {1'b0, m_acc} + ((v && !big) ? (49'd1 << c) : 49'd0);
    nxt = '0;
    nxt.sum = s[47:0];
    nxt.cnt = (v && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
    nxt.ecc = m_ecc | ecc;
`ifdef PCOEFF_OVERFLOW_CHECK_EN
    nxt.ovf = m_ovf | big | s[48];
`endif
    m_ovf = m_ovf | big | s[48];
    @(posedge clk);
    #1;
    if (popping) void'(q.pop_front());
    if (pend_v) begin
      if (full_before && !popping) m_lost = 1'b1;
      else q.push_back(pend);
    end
    pend_v = e;
    pend   = nxt;
    if (e) begin
      m_acc = '0; m_cnt = '0; m_ecc = 1'b0; m_ovf = 1'b0;
    end else begin
      m_acc = nxt.sum; m_cnt = nxt.cnt; m_ecc = nxt.ecc;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    resultValid     = 1'b0;
    connectCount    = 6'd0;
    batchEnd        = 1'b0;
    eccIn           = 1'b0;
    res_if.outReady = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    model_clear();
    do_reset();
    do_reset();
    // Counts 0,3,5 closing on the third: sum 41, count 3, valid two cycles later.
    step(1'b1, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'd5, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    // Back-to-back batches: no cycle lost at the boundary.
    step(1'b1, 6'd2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 6'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    // ECC pulse only in batch A.
    step(1'b1, 6'd4, 1'b0, 1'b1, 1'b1);
    step(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 6'd4, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    // Empty batch still produces a zero entry.
    step(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    // Wrap at 2^48 and out-of-range count.
    step(1'b1, 6'd47, 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'd47, 1'b1, 1'b0, 1'b1);
    step(1'b1, 6'd50, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    // Five batches with a stalled consumer: fifth is lost, head held.
    for (int k = 1; k <= 5; k++) step(1'b1, 6'(k), 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    // Batch closing while full lands on the first pop edge.
    step(1'b1, 6'd6, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);
    // Reset mid-batch discards the partial sum.
    step(1'b1, 6'd2, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 6'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcoeff_sum_collector.md
PCOEFF_SUM_COLLECTOR -- requirements
Module: pcoeff_sum_collector

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 48: width of the batch sum and of each decoded term.
REQ-002 SHALL have parameter BOT_COUNT_WIDTH, default 32: width of the per-batch valid-result counter.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 2: log2 of the number of result FIFO entries (default 4 entries).
REQ-004 SHALL have port clk, input, 1: the single clock; every register is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port resultValid, input, 1: connectCount is a real result this cycle.
REQ-007 SHALL have port connectCount, input, 6: connected-component count from the counting core.
REQ-008 SHALL have port batchEnd, input, 1: closes the batch after this cycle; sampled regardless of resultValid.
REQ-009 SHALL have port eccIn, input, 1: ECC status of the upstream core for this cycle.
REQ-010 SHALL have port almostFull, output, 1: throttle request to the bot source.
REQ-011 SHALL have port outValid, output, 1: a batch result is presented.
REQ-012 SHALL have port outReady, input, 1: the consumer accepts the presented batch result.
REQ-013 SHALL have port outSum, output, SUM_WIDTH: the batch sum of 2^connectCount.
REQ-014 SHALL have port outBotCount, output, BOT_COUNT_WIDTH: the number of valid results in the batch.
REQ-015 SHALL have port outEcc, output, 1: at least one eccIn was seen during the batch.
REQ-016 SHALL have port lostBatch, output, 1: sticky error, a batch was closed while the FIFO was full.

Function
REQ-017 Stage 1 (edge after sampling) SHALL register term = resultValid ? (1 << connectCount) : 0, together with resultValid, batchEnd and eccIn.
REQ-018 A term with connectCount >= SUM_WIDTH SHALL be 0.
REQ-019 Stage 2 SHALL set acc <= acc + term, cnt <= cnt + resultValid_s1 and eccAcc <= eccAcc | ecc_s1; the sum SHALL wrap modulo 2^SUM_WIDTH.
REQ-020 When batchEnd_s1 is set, stage 2 SHALL push {acc+term, cnt+valid, eccAcc|ecc} into the FIFO and load acc, cnt and eccAcc with 0 on the same edge, so no cycle is lost between batches.
REQ-021 Latency: for batchEnd sampled at cycle t with an empty FIFO, outValid SHALL be high at cycle t+2.
REQ-022 The FIFO SHALL be show-ahead with outValid = !empty; a pop SHALL occur on outValid && outReady.
REQ-023 outSum, outBotCount and outEcc SHALL be held stable while outValid && !outReady.
REQ-024 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-025 A push into a full FIFO with no simultaneous pop SHALL be discarded and SHALL set lostBatch, which stays set until reset.
REQ-026 almostFull SHALL be registered and high when used entries >= 2^FIFO_DEPTH_LOG2 - 2.
REQ-027 batchEnd with no valid result in the batch SHALL still push an entry with sum 0 and count 0.
REQ-028 The counter cnt SHALL saturate at all-ones.

Reset
REQ-029 While rst_n is low at an edge, the block SHALL clear the stage-1 registers, acc, cnt, eccAcc, the FIFO pointers and lostBatch (and ovf when PCOEFF_OVERFLOW_CHECK_EN is defined).
REQ-030 After reset, outValid, almostFull and lostBatch SHALL be 0 from the first cycle after the reset edge.
REQ-031 An in-flight batch at reset SHALL be discarded, and no partial entry SHALL be pushed.

Configuration
REQ-032 Macro PCOEFF_OVERFLOW_CHECK_EN, when defined, SHALL add output outOverflow (1 bit, a FIFO entry field).
REQ-033 With the macro defined, outOverflow SHALL be set if any term in the batch had connectCount >= SUM_WIDTH or the batch sum carried out of SUM_WIDTH.
REQ-034 Without the macro, the port and its logic SHALL be absent and wrap/zero behaviour SHALL be silent.

Structure
REQ-035 Shared package pcoeff_pkg SHALL hold the SUM_WIDTH and BOT_COUNT_WIDTH defaults, the connectCount width (6) and the packed FIFO entry typedef pcoeff_entry_t.
REQ-036 The FIFO SHALL be the single sub-module pcoeff_result_fifo: synchronous, show-ahead, register-based, parameterised on width and depth.

Verification
REQ-037 Scenario: counts 0, 3 and 5 valid, with batchEnd on the third -> one entry, outSum=41, outBotCount=3, outEcc=0, outValid at t+2.
REQ-038 Scenario: batchEnd on cycle t and the next batch's first valid count=1 on t+1 -> the first entry is unaffected and the second batch sum starts at 2.
REQ-039 Scenario: outReady=0 while 5 batches are closed -> almostFull goes high after 2 entries; the 5th batch sets lostBatch; the 4 stored entries drain in order once outReady=1.
REQ-040 Scenario: count=47 twice with SUM_WIDTH=48 and the macro defined -> outSum=0, outOverflow=1; without the macro -> outSum=0 with no flag.
REQ-041 Scenario: rst_n low for one cycle mid-batch after count=2 -> no entry is pushed; the next batch with count=0 gives outSum=1.
REQ-042 Scenario: eccIn pulse in batch A only -> A has outEcc=1 and batch B has outEcc=0.
